fb_arbiter: RTL

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 9 +
 rtl/fb_clear_engine.sv | 54 +++++
 rtl/fb_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the clear-engine state encoding.
package fb_pkg;
    localparam int FB_DEPTH = 384000;
    localparam int ADDR_W = 19;
    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 4'hF;

    typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/fb_clear_engine.sv
// Framebuffer fill sequencer: walks every entry once, stalling whenever scanout owns the RAM.
module fb_clear_engine import fb_pkg::*; #(
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
    parameter int ADDR_W   = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_start,
    input  logic [IDX_W-1:0]  clear_color,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] counter,
    output logic [IDX_W-1:0]  color
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);

    state_t state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            counter <= '0;
            color   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        counter <= '0;
                        color   <= clear_color;
                    end
                end
                CLEAR: begin
                    // A stalled cycle writes nothing, so the counter must hold.
                    if (!stall) begin
                        if (counter == LAST) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            counter <= '0;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scanout read beats clear fill, which beats drawer writes.
module fb_arbiter import fb_pkg::*; #(
    parameter int FB_DEPTH = fb_pkg::FB_DEPTH,
    parameter int ADDR_W   = fb_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [IDX_W-1:0]  vga_data,
    output logic              vga_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IDX_W-1:0]  wr_data,
    input  logic              clear_start,
    input  logic [IDX_W-1:0]  clear_color,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [IDX_W-1:0]  ram_wdata,
    input  logic [IDX_W-1:0]  ram_rdata
);
    logic [ADDR_W-1:0] clr_addr;
    logic [IDX_W-1:0]  clr_color;
    logic              wr_in_range;

    fb_clear_engine #(
        .FB_DEPTH(FB_DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .clear_start(clear_start),
        .clear_color(clear_color),
        .stall      (vga_req),
        .busy       (clear_busy),
        .done       (clear_done),
        .counter    (clr_addr),
        .color      (clr_color)
    );

    assign wr_ready    = !rst && !vga_req && !clear_busy;
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W + 1)'(FB_DEPTH));
    assign vga_data    = ram_rdata;

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (rst) begin
            ram_we = 1'b0;
        end else if (vga_req) begin
            ram_addr = vga_addr;
        end else if (clear_busy) begin
            ram_addr  = clr_addr;
            ram_wdata = clr_color;
            ram_we    = 1'b1;
        end else if (wr_valid) begin
            // Transparent pixels and off-screen addresses are consumed without touching RAM.
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
            ram_we    = (wr_data != TRANSPARENT_IDX) && wr_in_range;
        end
    end

    // Read data returns one cycle after the request; valid tracks that latency.
    always_ff @(posedge clk) begin
        if (rst) vga_valid <= 1'b0;
        else     vga_valid <= vga_req;
    end
endmodule
